multicycle_control_fsm: RTL and testbench

- Main sequencer of the multicycle datapath. It sits directly upstream of the ALU, ALUControl and the 3:1 operand mux, and drives their select and enable lines.
- It also drives the PC, IR, memory and register-file enables.
- It walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and waits on a memory-ready handshake.
- It counts retired instructions.

---
 rtl/multicycle_control_fsm.sv | 175 +++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multicycle datapath: steps each instruction through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_control_fsm #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          instructionType,
    input  logic [4:0]          opcode,
    input  logic                zero,
    input  logic                memReady,
    output logic                pcEn,
    output logic                iorD,
    output logic                memRead,
    output logic                memWrite,
    output logic                irWrite,
    output logic                regWrite,
    output logic [1:0]          regDataSel,
    output logic                aluSrcA,
    output logic [1:0]          aluSrcB,
    output logic [1:0]          aluOpSel,
    output logic [1:0]          pcSrc,
    output logic                illegalInstr,
    output logic [RETIRE_W-1:0] retireCount,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_EXEC_I  = 4'd3,
        S_ADDR    = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WB  = 4'd6,
        S_MEM_WR  = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ALU_WB  = 4'd10,
        S_SHIFT   = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    state_t              state_q, state_d;
    logic [RETIRE_W-1:0] retire_q;
    logic                retire_now;

    logic pcWrite_c, pcWriteCond_c, memRead_c, memWrite_c;
    logic irWrite_c, regWrite_c, illegal_c;

    logic is_jr, is_jal;
    assign is_jr  = (instructionType == 2'b00) && (opcode == 5'd4);
    assign is_jal = (instructionType == 2'b01) && (opcode == 5'd1);

    always_comb begin
        state_d    = S_FETCH;
        retire_now = 1'b0;
        case (state_q)
            S_FETCH:  state_d = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                state_d = S_ILLEGAL;
                case (instructionType)
                    2'b00: begin
                        if (opcode < 5'd4)       state_d = S_EXEC_R;
                        else if (opcode == 5'd4) state_d = S_JUMP;
                    end
                    2'b10: begin
                        if (opcode < 5'd2)       state_d = S_EXEC_I;
                        else if (opcode < 5'd4)  state_d = S_ADDR;
                        else if (opcode == 5'd4) state_d = S_BRANCH;
                    end
                    2'b01: if (opcode < 5'd2) state_d = S_JUMP;
                    default: if (opcode < 5'd4) state_d = S_SHIFT;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_SHIFT: state_d = S_ALU_WB;
            S_ADDR:   state_d = (opcode == 5'd2) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_d = memReady ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR: begin
                state_d    = memReady ? S_FETCH : S_MEM_WR;
                retire_now = memReady;
            end
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: retire_now = 1'b1;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcWrite_c     = 1'b0;
        pcWriteCond_c = 1'b0;
        memRead_c     = 1'b0;
        memWrite_c    = 1'b0;
        irWrite_c     = 1'b0;
        regWrite_c    = 1'b0;
        illegal_c     = 1'b0;
        iorD          = 1'b0;
        regDataSel    = 2'b00;
        aluSrcA       = 1'b0;
        aluSrcB       = 2'b00;
        aluOpSel      = 2'b00;
        pcSrc         = 2'b00;
        case (state_q)
            S_FETCH: begin
                memRead_c = 1'b1;
                aluSrcB   = 2'b01;
                irWrite_c = memReady;
                pcWrite_c = memReady;
            end
            S_DECODE: aluSrcB = 2'b10;
            S_EXEC_R, S_SHIFT: begin
                aluSrcA  = 1'b1;
                aluOpSel = 2'b10;
            end
            S_EXEC_I: begin
                aluSrcA  = 1'b1;
                aluSrcB  = 2'b10;
                aluOpSel = 2'b10;
            end
            S_ALU_WB: regWrite_c = 1'b1;
            S_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEM_RD: begin
                memRead_c = 1'b1;
                iorD      = 1'b1;
            end
            S_MEM_WB: begin
                regWrite_c = 1'b1;
                regDataSel = 2'b01;
            end
            S_MEM_WR: begin
                memWrite_c = 1'b1;
                iorD       = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA       = 1'b1;
                aluOpSel      = 2'b01;
                pcWriteCond_c = 1'b1;
                pcSrc         = 2'b01;
            end
            S_JUMP: begin
                pcWrite_c = 1'b1;
                pcSrc     = is_jr ? 2'b11 : 2'b10;
                if (is_jal) begin
                    regWrite_c = 1'b1;
                    regDataSel = 2'b10;
                end
            end
            S_ILLEGAL: illegal_c = 1'b1;
            default: ;
        endcase
    end

    // Reset masks every strobe so an in-flight write never reaches memory.
    assign pcEn         = ~reset & (pcWrite_c | (pcWriteCond_c & zero));
    assign memRead      = ~reset & memRead_c;
    assign memWrite     = ~reset & memWrite_c;
    assign irWrite      = ~reset & irWrite_c;
    assign regWrite     = ~reset & regWrite_c;
    assign illegalInstr = ~reset & illegal_c;
    assign retireCount  = retire_q;
    assign state        = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            retire_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire_now) retire_q <= retire_q + RETIRE_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench for multicycle_control_fsm.
module tb_multicycle_control_fsm;

    localparam int RW = 4;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] instructionType;
    logic [4:0] opcode;
    logic zero, memReady;
    logic pcEn, iorD, memRead, memWrite, irWrite, regWrite;
    logic [1:0] regDataSel, aluSrcB, aluOpSel, pcSrc;
    logic aluSrcA, illegalInstr;
    logic [RW-1:0] retireCount;
    logic [3:0] state;

    multicycle_control_fsm #(.RETIRE_W(RW)) dut (
        .clk(clk), .reset(reset),
        .instructionType(instructionType), .opcode(opcode),
        .zero(zero), .memReady(memReady),
        .pcEn(pcEn), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
        .irWrite(irWrite), .regWrite(regWrite), .regDataSel(regDataSel),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOpSel(aluOpSel),
        .pcSrc(pcSrc), .illegalInstr(illegalInstr),
        .retireCount(retireCount), .state(state)
    );

    always #5 clk = ~clk;

    typedef enum int {
        K_R, K_I, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_SH, K_ILL
    } kind_t;

    typedef struct packed {
        logic [3:0]    st;
        logic [15:0]   ctl;
        logic [RW-1:0] ret;
    } exp_t;

    typedef int path_t[$];

    exp_t expq[$];
    int checks = 0;
    int errors = 0;
    logic [RW-1:0] model_ret;

    function automatic kind_t classify(logic [1:0] t, logic [4:0] op);
        int o = int'(op);
        case (t)
            2'b00: return (o <= 3) ? K_R : (o == 4) ? K_JR : K_ILL;
            2'b10: begin
                if (o <= 1) return K_I;
                if (o == 2) return K_LW;
                if (o == 3) return K_SW;
                if (o == 4) return K_BEQ;
                return K_ILL;
            end
            2'b01: return (o == 0) ? K_J : (o == 1) ? K_JAL : K_ILL;
            default: return (o <= 3) ? K_SH : K_ILL;
        endcase
    endfunction

    // Sequence of state codes an instruction class visits.
    function automatic path_t path_of(kind_t k);
        case (k)
            K_R:   return '{0, 1, 2, 10};
            K_SH:  return '{0, 1, 11, 10};
            K_I:   return '{0, 1, 3, 10};
            K_LW:  return '{0, 1, 4, 5, 6};
            K_SW:  return '{0, 1, 4, 7};
            K_BEQ: return '{0, 1, 8};
            K_ILL: return '{0, 1, 12};
            default: return '{0, 1, 9};
        endcase
    endfunction

    function automatic logic [15:0] ctl_of(int s, kind_t k, logic mr,
                                           logic z, logic rst);
        logic pe, io, mrd, mwr, irw, rw, sa, il;
        logic [1:0] rds, sb, aop, ps;
        {pe, io, mrd, mwr, irw, rw, sa, il} = '0;
        {rds, sb, aop, ps} = '0;
        case (s)
            0: begin mrd = 1; sb = 2'b01; irw = mr; pe = mr; end
            1: sb = 2'b10;
            2, 11: begin sa = 1; aop = 2'b10; end
            3: begin sa = 1; sb = 2'b10; aop = 2'b10; end
            4: begin sa = 1; sb = 2'b10; end
            5: begin mrd = 1; io = 1; end
            6: begin rw = 1; rds = 2'b01; end
            7: begin mwr = 1; io = 1; end
            8: begin sa = 1; aop = 2'b01; ps = 2'b01; pe = z; end
            9: begin
                pe = 1;
                ps = (k == K_JR) ? 2'b11 : 2'b10;
                if (k == K_JAL) begin rw = 1; rds = 2'b10; end
            end
            10: rw = 1;
            12: il = 1;
            default: ;
        endcase
        if (rst) {pe, mrd, mwr, irw, rw, il} = '0;
        return {pe, io, mrd, mwr, irw, rw, rds, sa, sb, aop, ps, il};
    endfunction

    // waits < 0: random memory stalls; otherwise none in fetch and
    // exactly `waits` in the data-memory state.
    task automatic run_instr(input logic [1:0] t, input logic [4:0] op,
                             input int waits, input int zf,
                             input bit rst_last);
        kind_t k;
        path_t p;
        int s, nlow;
        logic mr, z, rr;
        exp_t e;
        k = classify(t, op);
        p = path_of(k);
        for (int i = 0; i < p.size(); i++) begin
            s = p[i];
            nlow = 0;
            if (s == 0 || s == 5 || s == 7) begin
                if (waits < 0) nlow = $urandom_range(0, 2);
                else if (s != 0) nlow = waits;
            end
            for (int w = 0; w <= nlow; w++) begin
                @(posedge clk);
                #1;
                rr = rst_last && (i == p.size() - 1) && (w == nlow);
                z = (zf < 0) ? 1'($urandom_range(0, 1)) : zf[0];
                if (s == 0 || s == 5 || s == 7) mr = (w == nlow);
                else mr = 1'($urandom_range(0, 1));
                reset = rr;
                memReady = mr;
                zero = z;
                if (s == 0) begin
                    instructionType = 2'($urandom_range(0, 3));
                    opcode = 5'($urandom_range(0, 31));
                end else begin
                    instructionType = t;
                    opcode = op;
                end
                e.st = 4'(s);
                e.ctl = ctl_of(s, k, mr, z, rr);
                e.ret = model_ret;
                expq.push_back(e);
            end
        end
        if (rst_last) model_ret = '0;
        else if (k != K_ILL) model_ret = model_ret + 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                act = {pcEn, iorD, memRead, memWrite, irWrite, regWrite,
                       regDataSel, aluSrcA, aluSrcB, aluOpSel, pcSrc,
                       illegalInstr};
                checks += 3;
                if (state !== e.st) begin
                    errors++;
                    $display("FAIL state t=%0t got %0d want %0d",
                             $time, state, e.st);
                end
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl t=%0t st=%0d got %h want %h",
                             $time, e.st, act, e.ctl);
                end
                if (retireCount !== e.ret) begin
                    errors++;
                    $display("FAIL retire t=%0t got %0d want %0d",
                             $time, retireCount, e.ret);
                end
            end
        end
    end

    initial begin : stim
        exp_t e;
        logic [1:0] t;
        logic [4:0] op;
        reset = 1'b1;
        memReady = 1'b1;
        zero = 1'b0;
        instructionType = 2'b00;
        opcode = 5'd0;
        model_ret = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
            e.st = 4'd0;
            e.ctl = ctl_of(0, K_R, 1'b1, 1'b0, 1'b1);
            e.ret = '0;
            expq.push_back(e);
        end
        run_instr(2'b00, 5'd1, 0, -1, 1'b0);
        run_instr(2'b10, 5'd2, 3, -1, 1'b0);
        run_instr(2'b10, 5'd4, 0, 1, 1'b0);
        run_instr(2'b10, 5'd4, 0, 0, 1'b0);
        run_instr(2'b01, 5'd3, 0, -1, 1'b0);
        run_instr(2'b00, 5'd4, -1, -1, 1'b0);
        run_instr(2'b01, 5'd1, -1, -1, 1'b0);
        run_instr(2'b10, 5'd3, 2, -1, 1'b0);
        for (int n = 0; n < 80; n++) begin
            t = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) op = 5'($urandom_range(0, 31));
            else op = 5'($urandom_range(0, 5));
            run_instr(t, op, -1, -1, 1'b0);
        end
        run_instr(2'b10, 5'd3, 0, -1, 1'b1);
        run_instr(2'b00, 5'd1, 0, -1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
